// File: rtl/tl_sram_adapter.sv
// TileLink-UL single-beat device in front of a single-port synchronous SRAM.
// Every A beat produces exactly one D beat, in order.
module tl_sram_adapter #(
    parameter int                   DataWidth   = 64,
    parameter int                   AddrWidth   = 56,
    parameter int                   SourceWidth = 3,
    parameter int                   SinkWidth   = 1,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0,
    parameter int                   MemDepth    = 1024,
    localparam int                  BB          = DataWidth / 8,
    localparam int                  IW          = $clog2(MemDepth)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   host_a_valid,
    output logic                   host_a_ready,
    input  logic [2:0]             host_a_opcode,
    input  logic [2:0]             host_a_param,
    input  logic [2:0]             host_a_size,
    input  logic [SourceWidth-1:0] host_a_source,
    input  logic [AddrWidth-1:0]   host_a_address,
    input  logic [BB-1:0]          host_a_mask,
    input  logic                   host_a_corrupt,
    input  logic [DataWidth-1:0]   host_a_data,

    output logic                   host_d_valid,
    input  logic                   host_d_ready,
    output logic [2:0]             host_d_opcode,
    output logic [1:0]             host_d_param,
    output logic [2:0]             host_d_size,
    output logic [SourceWidth-1:0] host_d_source,
    output logic [SinkWidth-1:0]   host_d_sink,
    output logic                   host_d_denied,
    output logic                   host_d_corrupt,
    output logic [DataWidth-1:0]   host_d_data,

    output logic                   host_b_valid,
    output logic                   host_c_ready,
    output logic                   host_e_ready,

    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [IW-1:0]          mem_addr_o,
    output logic [BB-1:0]          mem_wmask_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int OffW = $clog2(BB);

    typedef struct packed {
        logic                   data_resp;
        logic [2:0]             size;
        logic [SourceWidth-1:0] source;
        logic                   denied;
        logic [DataWidth-1:0]   data;
    } resp_t;

    logic                 w_is_get;
    logic                 w_is_put;
    logic [AddrWidth-1:0] w_addr_off;
    logic [AddrWidth-1:0] w_word;
    logic                 w_in_range;
    logic                 w_denied;
    logic                 w_a_fire;
    logic                 w_unused;

    assign w_is_get   = (host_a_opcode == 3'd4);
    assign w_is_put   = (host_a_opcode == 3'd0) || (host_a_opcode == 3'd1);
    // Addresses below BaseAddr wrap to huge offsets and fall out of range.
    assign w_addr_off = host_a_address - BaseAddr;
    assign w_word     = w_addr_off >> OffW;
    assign w_in_range = (w_word < AddrWidth'(MemDepth));
    assign w_denied   = !(w_is_get || w_is_put) || !w_in_range ||
                        (host_a_size > 3'(OffW)) || (w_is_put && host_a_corrupt);
    assign w_a_fire   = host_a_valid && host_a_ready;
    assign w_unused   = ^host_a_param;

    assign mem_req_o   = w_a_fire && !w_denied;
    assign mem_we_o    = w_is_put;
    assign mem_addr_o  = w_word[IW-1:0];
    assign mem_wmask_o = host_a_mask;
    assign mem_wdata_o = host_a_data;

    logic                   r_s1_valid;
    logic                   r_s1_data_resp;
    logic [2:0]             r_s1_size;
    logic [SourceWidth-1:0] r_s1_source;
    logic                   r_s1_denied;
    logic                   r_s1_read;

    resp_t       r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    resp_t       w_s1_resp;
    resp_t       w_d_resp;
    logic        w_fifo_nonempty;
    logic        w_d_fire;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occ;

    always_comb begin
        w_s1_resp           = '0;
        w_s1_resp.data_resp = r_s1_data_resp;
        w_s1_resp.size      = r_s1_size;
        w_s1_resp.source    = r_s1_source;
        w_s1_resp.denied    = r_s1_denied;
        w_s1_resp.data      = r_s1_read ? mem_rdata_i : '0;
    end

    // Stage 1 bypasses the FIFO only when the FIFO is empty.
    assign w_fifo_nonempty = (r_count != 2'd0);
    assign w_d_resp        = w_fifo_nonempty ? r_fifo[r_rd_ptr] : w_s1_resp;
    assign host_d_valid    = w_fifo_nonempty || r_s1_valid;
    assign w_d_fire        = host_d_valid && host_d_ready;
    assign w_push          = r_s1_valid && !(!w_fifo_nonempty && host_d_ready);
    assign w_pop           = w_fifo_nonempty && host_d_ready;

    // Credit: accept only if a response slot is guaranteed after this cycle.
    assign w_occ        = {1'b0, r_count} + {2'b00, r_s1_valid} - {2'b00, w_d_fire};
    assign host_a_ready = !rst_i && (w_occ < 3'd2);

    assign host_d_opcode  = {2'b00, w_d_resp.data_resp};
    assign host_d_param   = 2'd0;
    assign host_d_size    = w_d_resp.size;
    assign host_d_source  = w_d_resp.source;
    assign host_d_sink    = '0;
    assign host_d_denied  = w_d_resp.denied;
    assign host_d_corrupt = w_d_resp.denied && w_d_resp.data_resp;
    assign host_d_data    = w_d_resp.data;

    assign host_b_valid = 1'b0;
    assign host_c_ready = 1'b1;
    assign host_e_ready = 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            r_s1_valid <= w_a_fire;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_a_fire) begin
            r_s1_data_resp <= !w_is_put;
            r_s1_size      <= host_a_size;
            r_s1_source    <= host_a_source;
            r_s1_denied    <= w_denied;
            r_s1_read      <= w_is_get && !w_denied;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_s1_resp;
        end
    end

endmodule
